// File: rtl/flat_buffer_slice_sched_if.sv
// Frame-buffer / slice-scheduler bus: buffer fill side plus requester arbitration side.
interface flat_buffer_slice_sched_if #(
    parameter int buff_depth  = 5,
    parameter int delay_width = 4,
    parameter int width_width = 4,
    parameter int num_req     = 2
);
    localparam int tag_w  = delay_width + width_width;
    localparam int fill_w = $clog2(buff_depth + 2);
    localparam int idx_w  = $clog2(buff_depth + 1);

    logic                                 in_valid;
    logic                                 flush;
    logic [delay_width-1:0]               cfg_delay;
    logic [width_width-1:0]               cfg_width;
    logic                                 shift_en;
    logic [buff_depth:0][tag_w-1:0]       buffer_delay;
    logic [fill_w-1:0]                    fill_level;
    logic [num_req-1:0]                   req;
    logic [num_req-1:0][idx_w-1:0]        req_start;
    logic [num_req-1:0]                   gnt;
    logic [idx_w-1:0]                     slice_start;
    logic                                 slice_valid;
    logic                                 slice_err;

    modport master (
        output in_valid, flush, cfg_delay, cfg_width, req, req_start,
        input  shift_en, buffer_delay, fill_level, gnt, slice_start, slice_valid, slice_err
    );

    modport slave (
        input  in_valid, flush, cfg_delay, cfg_width, req, req_start,
        output shift_en, buffer_delay, fill_level, gnt, slice_start, slice_valid, slice_err
    );
endinterface

// File: rtl/flat_buffer_slice_sched.sv
// Frame buffer bookkeeping (fill level, tag array) and round-robin slice-start arbiter
// that only grants windows whose entries are all populated.
module flat_buffer_slice_sched #(
    parameter int buff_depth  = 5,
    parameter int slice_depth = 3,
    parameter int delay_width = 4,
    parameter int width_width = 4,
    parameter int num_req     = 2
) (
    input logic                      clk,
    input logic                      rstb,
    flat_buffer_slice_sched_if.slave bus
);
    localparam int tag_w     = delay_width + width_width;
    localparam int fill_w    = $clog2(buff_depth + 2);
    localparam int idx_w     = $clog2(buff_depth + 1);
    localparam int ptr_w     = (num_req > 1) ? $clog2(num_req) : 1;
    localparam int max_start = buff_depth - slice_depth;

    logic [fill_w-1:0]              fill_q;
    logic [buff_depth:0][tag_w-1:0] tags_q;
    logic [ptr_w-1:0]               ptr_q;
    logic [num_req-1:0]             gnt_q;
    logic [idx_w-1:0]               slice_start_q;
    logic                           slice_valid_q;
    logic                           slice_err_q;

    logic [num_req-1:0]             legal;
    logic [num_req-1:0]             ready;
    logic [num_req-1:0]             eligible;
    logic [2*num_req-1:0]           elig_rot;
    logic                           found;
    logic                           grant;
    logic [ptr_w-1:0]               pick;
    logic [ptr_w-1:0]               ptr_next;

    assign bus.shift_en     = bus.in_valid & ~bus.flush;
    assign bus.buffer_delay = tags_q;
    assign bus.fill_level   = fill_q;
    assign bus.gnt          = gnt_q;
    assign bus.slice_start  = slice_start_q;
    assign bus.slice_valid  = slice_valid_q;
    assign bus.slice_err    = slice_err_q;

    // 32-bit compares so start+slice_depth+1 can never wrap.
    for (genvar i = 0; i < num_req; i++) begin : g_req
        logic [31:0] start_ext;
        assign start_ext   = 32'(bus.req_start[i]);
        assign legal[i]    = start_ext <= 32'(max_start);
        assign ready[i]    = legal[i] & (32'(fill_q) >= start_ext + 32'(slice_depth) + 32'd1);
        assign eligible[i] = bus.req[i] & ~gnt_q[i] & (ready[i] | ~legal[i]);
    end

    // Rotate so bit 0 is the pointer position; first set bit wins.
    assign elig_rot = {eligible, eligible} >> ptr_q;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int off = 0; off < num_req; off++) begin
            if (!found && elig_rot[off]) begin
                found = 1'b1;
                pick  = ptr_w'((int'(ptr_q) + off >= num_req) ? int'(ptr_q) + off - num_req
                                                               : int'(ptr_q) + off);
            end
        end
    end

    assign grant    = found & ~bus.flush;
    assign ptr_next = (pick == ptr_w'(num_req - 1)) ? '0 : pick + ptr_w'(1);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fill_q <= '0;
            tags_q <= '0;
        end else if (bus.flush) begin
            fill_q <= '0;
            tags_q <= '0;
        end else if (bus.in_valid) begin
            if (fill_q != fill_w'(buff_depth + 1))
                fill_q <= fill_q + fill_w'(1);
            tags_q <= {tags_q[buff_depth-1:0], {bus.cfg_delay, bus.cfg_width}};
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ptr_q         <= '0;
            gnt_q         <= '0;
            slice_start_q <= '0;
            slice_valid_q <= 1'b0;
            slice_err_q   <= 1'b0;
        end else begin
            gnt_q         <= '0;
            slice_valid_q <= 1'b0;
            if (grant) begin
                gnt_q         <= num_req'(1) << pick;
                slice_start_q <= bus.req_start[pick];
                slice_valid_q <= legal[pick];
                slice_err_q   <= ~legal[pick];
                ptr_q         <= ptr_next;
            end
        end
    end
endmodule

// File: tb/tb_flat_buffer_slice_sched.sv
// Directed and randomized checks of the slice scheduler against a behavioural model.
module tb_flat_buffer_slice_sched;
    localparam int BD = 5, SD = 3, DW = 4, WW = 4, NR = 2;
    localparam int MAXS = BD - SD;

    logic clk  = 1'b0;
    logic rstb = 1'b1;

    flat_buffer_slice_sched_if #(.buff_depth(BD), .delay_width(DW), .width_width(WW),
                                 .num_req(NR)) bus();

    flat_buffer_slice_sched #(.buff_depth(BD), .slice_depth(SD), .delay_width(DW),
                              .width_width(WW), .num_req(NR))
        dut (.clk(clk), .rstb(rstb), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int       m_fill, m_ptr, m_start;
    bit       m_valid, m_err;
    bit [1:0] m_gnt;
    int       m_tag[BD+1];

    task automatic model_reset();
        m_fill = 0; m_ptr = 0; m_start = 0; m_valid = 0; m_err = 0; m_gnt = 0;
        for (int e = 0; e <= BD; e++) m_tag[e] = 0;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.flush = 0; bus.cfg_delay = '0; bus.cfg_width = '0;
        bus.req = '0; bus.req_start = '0;
    endtask

    // advance one clock edge, predicting the post-edge state from the pre-edge inputs
    task automatic step();
        int pick, pstart, i, s, tag;
        bit lg, rd, plegal;
        pick = -1; pstart = 0; plegal = 0;
        if (!bus.flush) begin
            for (int off = 0; off < NR; off++) begin
                i  = (m_ptr + off) % NR;
                s  = int'(bus.req_start[i]);
                lg = (s <= MAXS);
                rd = lg && (m_fill >= s + SD + 1);
                if (pick < 0 && bus.req[i] && !m_gnt[i] && (rd || !lg)) begin
                    pick = i; pstart = s; plegal = lg;
                end
            end
        end
        tag = int'(bus.cfg_delay) * (1 << WW) + int'(bus.cfg_width);
        @(posedge clk);
        #1;
        if (bus.flush) begin
            m_fill = 0;
            for (int e = 0; e <= BD; e++) m_tag[e] = 0;
        end else if (bus.in_valid) begin
            m_fill = (m_fill == BD + 1) ? m_fill : m_fill + 1;
            for (int e = BD; e > 0; e--) m_tag[e] = m_tag[e-1];
            m_tag[0] = tag;
        end
        m_gnt = 0; m_valid = 0;
        if (pick >= 0) begin
            m_gnt[pick] = 1; m_start = pstart; m_valid = plegal; m_err = !plegal;
            m_ptr = (pick + 1) % NR;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rstb = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
        model_reset();
        total++; if (bus.fill_level !== 3'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", bus.fill_level); end
        total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
        total++; if (bus.slice_start !== 3'd0 || bus.slice_valid !== 1'b0 || bus.slice_err !== 1'b0) begin
            bad++; $display("FAIL reset_slice: got start=%0d valid=%b err=%b want 0/0/0",
                            bus.slice_start, bus.slice_valid, bus.slice_err); end
        total++; if (bus.buffer_delay !== '0) begin bad++; $display("FAIL reset_tags: got %h want 0", bus.buffer_delay); end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 7; k++) begin
            bus.in_valid = 1; bus.cfg_delay = 4'(k); bus.cfg_width = '0;
            #1;
            total++; if (bus.shift_en !== 1'b1) begin bad++; $display("FAIL fill_shift_en: got %b want 1", bus.shift_en); end
            step();
            total++; if (bus.fill_level !== 3'((k > 6) ? 6 : k)) begin
                bad++; $display("FAIL fill_level[%0d]: got %0d want %0d", k, bus.fill_level, (k > 6) ? 6 : k); end
            if (k == 6) begin
                total++; if (bus.buffer_delay[0] !== 8'h60 || bus.buffer_delay[5] !== 8'h10) begin
                    bad++; $display("FAIL fill_tags: got [0]=%h [5]=%h want 60 10",
                                    bus.buffer_delay[0], bus.buffer_delay[5]); end
            end
        end
        total++; if (bus.buffer_delay[5] !== 8'h20) begin bad++; $display("FAIL fill_discard: got %h want 20", bus.buffer_delay[5]); end
        bus.in_valid = 0;
        #1;
        total++; if (bus.shift_en !== 1'b0) begin bad++; $display("FAIL fill_shift_idle: got %b want 0", bus.shift_en); end
    endtask

    task automatic test_ready_wait();
        idle_inputs();
        bus.flush = 1; step(); bus.flush = 0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1; bus.cfg_delay = 4'($urandom_range(0, 15)); bus.cfg_width = 4'($urandom_range(0, 15));
            step();
        end
        bus.in_valid = 0;
        bus.req[0] = 1; bus.req_start[0] = 3'd2;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL wait_no_gnt: got %b want 00", bus.gnt); end
        end
        bus.in_valid = 1; step(); bus.in_valid = 0;
        total++; if (bus.gnt !== 2'b00 || bus.fill_level !== 3'd6) begin
            bad++; $display("FAIL wait_sixth: got gnt=%b fill=%0d want 00 6", bus.gnt, bus.fill_level); end
        step();
        total++; if (bus.gnt !== 2'b01 || bus.slice_start !== 3'd2 || bus.slice_valid !== 1'b1 || bus.slice_err !== 1'b0) begin
            bad++; $display("FAIL wait_grant: got gnt=%b start=%0d v=%b e=%b want 01 2 1 0",
                            bus.gnt, bus.slice_start, bus.slice_valid, bus.slice_err); end
        bus.req = '0; step();
        total++; if (bus.gnt !== 2'b00 || bus.slice_valid !== 1'b0 || bus.slice_start !== 3'd2) begin
            bad++; $display("FAIL wait_after: got gnt=%b v=%b start=%0d want 00 0 2",
                            bus.gnt, bus.slice_valid, bus.slice_start); end
    endtask

    task automatic test_illegal();
        bus.req[1] = 1; bus.req_start[1] = 3'd3;
        step();
        total++; if (bus.gnt !== 2'b10 || bus.slice_start !== 3'd3 || bus.slice_valid !== 1'b0 || bus.slice_err !== 1'b1) begin
            bad++; $display("FAIL illegal_grant: got gnt=%b start=%0d v=%b e=%b want 10 3 0 1",
                            bus.gnt, bus.slice_start, bus.slice_valid, bus.slice_err); end
        bus.req = '0; step();
        total++; if (bus.gnt !== 2'b00 || bus.slice_err !== 1'b1) begin
            bad++; $display("FAIL illegal_hold: got gnt=%b e=%b want 00 1", bus.gnt, bus.slice_err); end
    endtask

    task automatic test_round_robin();
        idle_inputs();
        #2 rstb = 1'b0; #1 rstb = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) begin bus.in_valid = 1; step(); end
        bus.in_valid = 0;
        bus.req = 2'b11; bus.req_start[0] = 3'd0; bus.req_start[1] = 3'd1;
        for (int c = 0; c < 4; c++) begin
            step();
            total++; if (bus.gnt !== ((c % 2) ? 2'b10 : 2'b01) || bus.slice_start !== 3'(c % 2)) begin
                bad++; $display("FAIL rr_seq[%0d]: got gnt=%b start=%0d want %b %0d",
                                c, bus.gnt, bus.slice_start, (c % 2) ? 2'b10 : 2'b01, c % 2); end
        end
        bus.req = '0; step();
    endtask

    task automatic test_flush();
        int first;
        bus.flush = 1; bus.in_valid = 1; bus.req[0] = 1; bus.req_start[0] = 3'd0;
        #1;
        total++; if (bus.shift_en !== 1'b0) begin bad++; $display("FAIL flush_shift_en: got %b want 0", bus.shift_en); end
        step();
        total++; if (bus.gnt !== 2'b00 || bus.fill_level !== 3'd0 || bus.buffer_delay !== '0) begin
            bad++; $display("FAIL flush_clear: got gnt=%b fill=%0d tags=%h want 00 0 0",
                            bus.gnt, bus.fill_level, bus.buffer_delay); end
        bus.flush = 0;
        first = -1;
        for (int k = 1; k <= 10 && first < 0; k++) begin
            step();
            if (bus.gnt !== 2'b00) begin first = k; bus.req = '0; end
        end
        total++; if (first != 5) begin bad++; $display("FAIL flush_regrant: got cycle %0d want 5", first); end
        bus.in_valid = 0; step();
    endtask

    task automatic test_async_reset();
        bit seen;
        seen = 0;
        bus.req[0] = 1; bus.req_start[0] = 3'd0;
        for (int k = 0; k < 6 && !seen; k++) begin
            step();
            if (bus.gnt !== 2'b00) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL async_setup: got no grant want grant within 6 cycles"); end
        #2 rstb = 1'b0;
        #1;
        total++; if (bus.gnt !== 2'b00 || bus.slice_valid !== 1'b0 || bus.fill_level !== 3'd0) begin
            bad++; $display("FAIL async_reset: got gnt=%b v=%b fill=%0d want 00 0 0",
                            bus.gnt, bus.slice_valid, bus.fill_level); end
        idle_inputs();
        #1 rstb = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.cfg_delay = 4'($urandom_range(0, 15));
            bus.cfg_width = 4'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) begin
                if (bus.req[i] && m_gnt[i]) bus.req[i] = 1'b0;
                else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_start[i] = 3'($urandom_range(0, 5));
                end
            end
            #1;
            total++; if (bus.shift_en !== (bus.in_valid & ~bus.flush)) begin
                bad++; $display("FAIL rnd_shift_en[%0d]: got %b want %b", c, bus.shift_en, bus.in_valid & ~bus.flush); end
            step();
            total++; if (bus.fill_level !== 3'(m_fill)) begin
                bad++; $display("FAIL rnd_fill[%0d]: got %0d want %0d", c, bus.fill_level, m_fill); end
            total++; if (bus.gnt !== m_gnt) begin
                bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, bus.gnt, m_gnt); end
            total++; if (bus.slice_start !== 3'(m_start) || bus.slice_valid !== m_valid || bus.slice_err !== m_err) begin
                bad++; $display("FAIL rnd_slice[%0d]: got %0d/%b/%b want %0d/%b/%b", c,
                                bus.slice_start, bus.slice_valid, bus.slice_err, m_start, m_valid, m_err); end
            for (int e = 0; e <= BD; e++) begin
                total++; if (bus.buffer_delay[e] !== 8'(m_tag[e])) begin
                    bad++; $display("FAIL rnd_tag[%0d][%0d]: got %h want %h", c, e, bus.buffer_delay[e], 8'(m_tag[e])); end
            end
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_fill();
        test_ready_wait();
        test_illegal();
        test_round_robin();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
